// File: rtl/core_div_seq.sv
// Multi-cycle restoring radix-2 divide sequencer for the EX stage.
// Stalls the pipeline through halt while iterating one quotient bit per cycle.
module core_div_seq #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             halt,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_nx_s;
    logic [WIDTH-1:0] dvd_r, dvs_r, pr_r;
    logic [CW-1:0]    cnt_r;
    logic             neg_q_r, neg_r_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             dbz_r;
    logic             halt_s, done_s;

    logic             accept_s, zero_div_s, qbit_s, last_s;
    logic [WIDTH:0]   pr_shift_s, diff_s;
    logic [WIDTH-1:0] pr_next_s, q_next_s;

    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
        return {WIDTH{1'b0}} - v;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return (SIGNED && v[WIDTH-1]) ? neg_val(v) : v;
    endfunction

    assign accept_s   = (state_r == ST_IDLE) & start & ~flush;
    assign zero_div_s = (divisor == {WIDTH{1'b0}});

    // One restoring step: the partial remainder is widened by one bit so the
    // trial subtraction's borrow lands in the MSB.
    assign pr_shift_s = {pr_r, dvd_r[WIDTH-1]};
    assign diff_s     = pr_shift_s - {1'b0, dvs_r};
    assign qbit_s     = ~diff_s[WIDTH];
    assign pr_next_s  = qbit_s ? diff_s[WIDTH-1:0] : pr_shift_s[WIDTH-1:0];
    assign q_next_s   = {dvd_r[WIDTH-2:0], qbit_s};
    assign last_s     = (cnt_r == CNT_ONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; flush dominates every state.
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nx_s = zero_div_s ? ST_DONE : ST_BUSY;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (last_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_BUSY;
                    end
                end
                ST_DONE: state_nx_s = ST_IDLE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Stall and completion strobes; halt must react in the same cycle as start.
    always_comb begin
        halt_s = 1'b0;
        done_s = 1'b0;
        if (!rst || flush) begin
            halt_s = 1'b0;
            done_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: halt_s = start;
                ST_BUSY: halt_s = 1'b1;
                ST_DONE: done_s = 1'b1;
                default: begin
                    halt_s = 1'b0;
                    done_s = 1'b0;
                end
            endcase
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            pr_r        <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else if (accept_s) begin
            if (zero_div_s) begin
                quotient_r  <= {WIDTH{1'b1}};
                remainder_r <= dividend;
                dbz_r       <= 1'b1;
            end else begin
                dvd_r   <= abs_val(dividend);
                dvs_r   <= abs_val(divisor);
                pr_r    <= {WIDTH{1'b0}};
                cnt_r   <= CNT_INIT;
                neg_q_r <= SIGNED & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r_r <= SIGNED & dividend[WIDTH-1];
                dbz_r   <= 1'b0;
            end
        end else if ((state_r == ST_BUSY) && !flush) begin
            pr_r  <= pr_next_s;
            dvd_r <= q_next_s;
            cnt_r <= cnt_r - CNT_ONE;
            // Results only move on the final step, so a flushed op leaves them intact.
            if (last_s) begin
                quotient_r  <= neg_q_r ? neg_val(q_next_s) : q_next_s;
                remainder_r <= neg_r_r ? neg_val(pr_next_s) : pr_next_s;
            end
        end
    end

    assign halt        = halt_s;
    assign done        = done_s;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_core_div_seq.sv
// Self-checking bench for core_div_seq: signed and unsigned instances share stimulus.
module tb_core_div_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [W-1:0] dividend, divisor;
    logic         halt_s, done_s, dbz_s;
    logic [W-1:0] q_s, r_s;
    logic         halt_u, done_u, dbz_u;
    logic [W-1:0] q_u, r_u;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pulses = 0;

    core_div_seq #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .dividend(dividend), .divisor(divisor),
        .halt(halt_s), .done(done_s), .quotient(q_s), .remainder(r_s),
        .div_by_zero(dbz_s)
    );

    core_div_seq #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .dividend(dividend), .divisor(divisor),
        .halt(halt_u), .done(done_u), .quotient(q_u), .remainder(r_u),
        .div_by_zero(dbz_u)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done_s === 1'b1) pulses <= pulses + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit values; SV / truncates toward zero and % follows dividend sign.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sg,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sg) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called just after a rising edge; returns just after the edge that leaves DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] qs, input logic [W-1:0] rs,
                          input logic [W-1:0] qu, input logic [W-1:0] ru,
                          input logic dbz, input string tag, output int done_cyc);
        int t;
        int lat;
        bit seen;
        bit halt_bad;
        lat      = (b == 0) ? 1 : W + 1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        flush    = 1'b0;
        seen     = 1'b0;
        halt_bad = 1'b0;
        t        = 0;
        done_cyc = -1;
        while (!seen && t < 80) begin
            @(negedge clk);
            if (done_s === 1'b1) begin
                seen     = 1'b1;
                done_cyc = cyc;
                chk({tag, " latency"}, t, lat);
                chk({tag, " halt_at_done"}, halt_s, 1'b0);
                chk({tag, " done_u"}, done_u, 1'b1);
                chk({tag, " q_signed"}, q_s, qs);
                chk({tag, " r_signed"}, r_s, rs);
                chk({tag, " q_unsigned"}, q_u, qu);
                chk({tag, " r_unsigned"}, r_u, ru);
                chk({tag, " dbz_signed"}, dbz_s, dbz);
                chk({tag, " dbz_unsigned"}, dbz_u, dbz);
                start = 1'b0;
            end else if (halt_s !== 1'b1 || halt_u !== 1'b1 || done_u !== 1'b0) begin
                halt_bad = 1'b1;
            end
            @(posedge clk);
            #1;
            t++;
        end
        chk({tag, " done_seen"}, seen, 1'b1);
        chk({tag, " halt_window"}, halt_bad, 1'b0);
    endtask

    typedef struct {
        logic [W-1:0] a, b, qs, rs, qu, ru;
        logic         dbz;
        string        name;
    } vec_t;

    initial begin
        vec_t vecs[9];
        int   dc, dc1, dc2, p0;
        logic [W-1:0] a, b, qs, rs, qu, ru;

        vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 32'd2, 1'b0, "div_100_7"};
        vecs[1] = '{32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1, 1'b0, "div_m7_2"};
        vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000, 1'b0, "div_minneg_m1"};
        vecs[3] = '{32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 32'hFFFF_FFFF, 32'd55, 1'b1, "div_55_0"};
        vecs[4] = '{32'd9, 32'd3, 32'd3, 32'd0, 32'd3, 32'd0, 1'b0, "div_9_3"};
        vecs[5] = '{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 32'd0, 32'd7, 1'b0, "div_7_m2"};
        vecs[6] = '{32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'd4, 32'd0, 32'd0, 32'hFFFF_FFF0, 1'b0, "div_m16_m4"};
        vecs[7] = '{32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, "div_0_5"};
        vecs[8] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, "div_m1_1"};

        // Reset held with start asserted must keep everything quiet.
        rst      = 1'b0;
        start    = 1'b1;
        flush    = 1'b0;
        dividend = 32'd5;
        divisor  = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset halt", halt_s, 1'b0);
        chk("reset done", done_s, 1'b0);
        chk("reset quotient", q_s, 32'd0);
        chk("reset remainder", r_s, 32'd0);
        chk("reset dbz", dbz_s, 1'b0);
        chk("reset quotient_u", q_u, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("release halt same cycle", halt_s, 1'b1);
        start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle after release", halt_s, 1'b0);
        @(posedge clk);
        #1;

        // Table vectors, applied back-to-back.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].qs, vecs[i].rs, vecs[i].qu, vecs[i].ru,
                   vecs[i].dbz, vecs[i].name, dc);
        end

        // Back-to-back spacing: two pulses exactly 34 cycles apart.
        p0 = pulses;
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 32'd2, 1'b0, "b2b_first", dc1);
        run_op(32'd20, 32'd4, 32'd5, 32'd0, 32'd5, 32'd0, 1'b0, "b2b_second", dc2);
        chk("b2b spacing", dc2 - dc1, 32'd34);
        chk("b2b pulse count", pulses - p0, 32'd2);

        // Flush mid-operation keeps the previous result and aborts cleanly.
        run_op(32'd50, 32'd5, 32'd10, 32'd0, 32'd10, 32'd0, 1'b0, "pre_flush", dc);
        p0       = pulses;
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush halt", halt_s, 1'b0);
        chk("flush done", done_s, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post flush idle", halt_s, 1'b0);
        chk("post flush quotient", q_s, 32'd10);
        chk("post flush quotient_u", q_u, 32'd10);
        chk("post flush remainder", r_s, 32'd0);
        @(posedge clk);
        #1;
        chk("flush no pulse", pulses - p0, 32'd0);
        run_op(32'd20, 32'd4, 32'd5, 32'd0, 32'd5, 32'd0, 1'b0, "flush_restart", dc);

        // Randomised operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                3: b = 32'd0 - 32'($urandom_range(1, 15));
                4: begin
                    a = 32'($urandom_range(0, 1000));
                    b = $urandom;
                end
                default: b = $urandom;
            endcase
            model(a, b, 1'b1, qs, rs);
            model(a, b, 1'b0, qu, ru);
            run_op(a, b, qs, rs, qu, ru, (b == 0), "random", dc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
